// File: rtl/alu_shift_seq_pkg.sv
// alu_shift_seq_pkg: shift op codes and sequencer FSM state encodings
package alu_shift_seq_pkg;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROL = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_e;
endpackage

// File: rtl/alu_shift_1bit.sv
// alu_shift_1bit: combinational single-step shift/rotate of an N-bit operand
module alu_shift_1bit
  import alu_shift_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  op_e          S,
  output logic [N-1:0] Z
);
  always_comb begin
    Z = S == OP_SLL ? {A[N-2:0], 1'b0} :
        S == OP_SRL ? {1'b0, A[N-1:1]} :
        S == OP_SRA ? {A[N-1], A[N-1:1]} :
                      {A[N-2:0], A[N-1]};
  end
endmodule

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle shift sequencer applying one 1-bit step per clock
module alu_shift_seq
  import alu_shift_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [1:0]    S,
  input  logic [SW-1:0] amt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Z
);
  state_e        r_state, w_next;
  op_e           r_op;
  logic [N-1:0]  r_acc, r_z, w_step;
  logic [SW-1:0] r_cnt;
  logic          w_accept, w_last;

  alu_shift_1bit #(.N(N)) u_step (.A(r_acc), .S(r_op), .Z(w_step));

  always_comb begin
    w_accept = start && (r_state != ST_SHIFT);
    w_last   = r_cnt == SW'(1);
    w_next   = w_accept ? (amt == '0 ? ST_DONE : ST_SHIFT) :
               r_state == ST_SHIFT ? (w_last ? ST_DONE : ST_SHIFT) : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SLL;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= A;
        r_op  <= op_e'(S);
        r_cnt <= amt;
        if (amt == '0) r_z <= A;
      end else if (r_state == ST_SHIFT) begin
        r_acc <= w_step;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) r_z <= w_step;
      end
    end
  end

  assign busy = r_state == ST_SHIFT;
  assign done = r_state == ST_DONE;
  assign Z    = r_z;
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed and random checks of the shift sequencer against an arithmetic model
module tb_alu_shift_seq;
  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] A = '0;
  logic [1:0] S = '0;
  logic [2:0] amt = '0;
  logic       busy, done;
  logic [3:0] Z;
  logic [3:0] prev_z = '0;
  int compared = 0, mismatched = 0;

  alu_shift_seq #(.N(4), .SW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .S(S), .amt(amt),
    .busy(busy), .done(done), .Z(Z)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [3:0] a, input logic [1:0] s, input int m);
    int v, r;
    v = int'(a);
    case (s)
      2'b00: v = (v << m) & 15;
      2'b01: v = v >> m;
      2'b10: v = m >= 4 ? (a[3] ? 15 : 0) : ((v | (a[3] ? 32'hFFFF_FFF0 : 0)) >>> m) & 15;
      default: begin
        r = m % 4;
        v = ((v << r) | (v >> (4 - r))) & 15;
      end
    endcase
    return 4'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] a, input logic [1:0] s, input logic [2:0] m);
    A = a; S = s; amt = m; start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic finish_op(input logic [3:0] a, input logic [1:0] s, input logic [2:0] m, input bit noisy);
    logic [3:0] exp;
    exp = model(a, s, int'(m));
    for (int k = 1; k <= int'(m); k++) begin
      @(negedge clk);
      check("busy_in_shift", 32'(busy), 1);
      check("no_done_in_shift", 32'(done), 0);
      check("z_stable_in_shift", 32'(Z), 32'(prev_z));
      if (noisy) begin
        start = 1; A = 4'($urandom); S = 2'($urandom); amt = 3'($urandom);
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 1);
    check("busy_low_at_done", 32'(busy), 0);
    check("z_result", 32'(Z), 32'(exp));
    prev_z = exp;
  endtask

  task automatic idle_check();
    start = 0;
    @(negedge clk);
    check("idle_done_low", 32'(done), 0);
    check("idle_busy_low", 32'(busy), 0);
    check("idle_z_hold", 32'(Z), 32'(prev_z));
  endtask

  task automatic run_op(input logic [3:0] a, input logic [1:0] s, input logic [2:0] m, input bit noisy);
    start_op(a, s, m);
    finish_op(a, s, m, noisy);
    idle_check();
  endtask

  initial begin
    logic [3:0] ra;
    logic [1:0] rs;
    logic [2:0] rm;
    repeat (2) @(negedge clk);
    check("reset_z", 32'(Z), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    rst = 0;
    @(negedge clk);
    run_op(4'b0011, 2'b00, 3'd2, 0);
    check("t1_sll", 32'(Z), 32'(4'b1100));
    run_op(4'b1000, 2'b10, 3'd3, 0);
    check("t2_sra", 32'(Z), 32'(4'b1111));
    run_op(4'b1000, 2'b01, 3'd3, 0);
    check("t2_srl", 32'(Z), 32'(4'b0001));
    run_op(4'b1001, 2'b11, 3'd5, 0);
    check("t3_rol", 32'(Z), 32'(4'b0011));
    run_op(4'b0110, 2'b10, 3'd0, 0);
    check("t4_pass", 32'(Z), 32'(4'b0110));
    // start held with junk inputs through SHIFT, then a real op launched in the DONE cycle
    start_op(4'b0101, 2'b00, 3'd3);
    finish_op(4'b0101, 2'b00, 3'd3, 1);
    start_op(4'b1100, 2'b11, 3'd2);
    finish_op(4'b1100, 2'b11, 3'd2, 0);
    check("t5_b2b", 32'(Z), 32'(4'b0011));
    idle_check();
    start_op(4'b1011, 2'b00, 3'd3);
    @(negedge clk);
    check("t6_busy_before_rst", 32'(busy), 1);
    rst = 1;
    #1;
    check("t6_rst_z", 32'(Z), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 0;
    prev_z = '0;
    idle_check();
    run_op(4'b1011, 2'b00, 3'd1, 0);
    check("t6_after", 32'(Z), 32'(4'b0110));
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom); rs = 2'($urandom); rm = 3'($urandom_range(0, 7));
      start_op(ra, rs, rm);
      finish_op(ra, rs, rm, ($urandom % 2) == 1);
      if ($urandom % 2 == 1) begin
        ra = 4'($urandom); rs = 2'($urandom); rm = 3'($urandom_range(0, 7));
        start_op(ra, rs, rm);
        finish_op(ra, rs, rm, 0);
      end
      idle_check();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
